// File: rtl/seq_pkg.sv
// Shared types and opcodes for the fetch/execute sequencer.
package seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, IRQ, HALT} state_t;

  localparam logic [7:0] RETI_OPCODE = 8'hFF;
  localparam logic [7:0] NOP_OPCODE  = 8'h00;
endpackage

// File: rtl/seq_fetch_timer.sv
// Fetch watchdog: flags the cycle in which TIMEOUT consecutive FETCH cycles pass with no ack.
// Combinational flag from a registered count; clears whenever ack arrives or FETCH is left.
module seq_fetch_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetching,
  input  logic ack,
  output logic timeout
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fetching && !ack) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // cnt holds the number of earlier unacked cycles, so this is the TIMEOUT-th one
  assign timeout = fetching && !ack && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute controller: PC/IR, imem req/ack fetch, RF write gating, single-level IRQ/RETI.
// Two cycles minimum per instruction; FETCH holds req until ack (watchdog HALT under SEQ_WATCHDOG_EN).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W         = 8,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned IRQ_VECTOR   = 32'hF0,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      ir,
  input  logic            dec_reg_write,
  output logic            rf_we,
  input  logic            irq,
  output logic            irq_ack,
  output logic            in_isr,
  output logic            fetch_err
);
  localparam logic [PC_W-1:0] VEC_PC  = PC_W'(IRQ_VECTOR);
  localparam logic [PC_W-1:0] BOOT_PC = PC_W'(RESET_PC);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] saved_pc;
  logic            is_reti;
  logic            in_isr_next;
  logic            timeout;

  assign is_reti     = (ir == RETI_OPCODE);
  assign in_isr_next = is_reti ? 1'b0 : in_isr;

`ifdef SEQ_WATCHDOG_EN
  seq_fetch_timer #(
    .TIMEOUT (IMEM_TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetching (state == FETCH),
    .ack      (imem_ack),
    .timeout  (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^IMEM_TIMEOUT;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= BOOT_PC;
      ir        <= NOP_OPCODE;
      saved_pc  <= '0;
      in_isr    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_en) state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= EXEC;
          end else if (timeout) begin
            fetch_err <= 1'b1;
            state     <= HALT;
          end
        end
        EXEC: begin
          if (is_reti) begin
            pc     <= saved_pc;
            in_isr <= 1'b0;
          end
          // RETI with irq pending re-enters at once; IRQ then saves the restored pc
          if (irq && !in_isr_next) state <= IRQ;
          else if (run_en)         state <= FETCH;
          else                     state <= IDLE;
        end
        IRQ: begin
          saved_pc <= pc;
          pc       <= VEC_PC;
          in_isr   <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign irq_ack   = (state == IRQ);
  assign rf_we     = (state == EXEC) && dec_reg_write && !is_reti;
endmodule
